key_entry_ctrl: RTL and testbench

- Sits directly downstream of the keypad scanner.
- Consumes the scanner's 4-bit key code and key-held flag, debounces press and release, and turns each physical press into exactly one event.
- Accumulates digit keys into a multi-digit BCD operand and presents operand plus operator to the calculator core over a valid/ready handshake.

---
 rtl/key_entry_ctrl.sv | 156 +++++++++++++++
 tb/tb_key_entry_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: debounces scanner key presses/releases, turns each press into one
// event, accumulates BCD digits into an operand and hands operand + operator to the
// calculator core over a valid/ready handshake.
// Optional feature: define KEY_BACKSPACE_EN to make key F delete the last digit.
module key_entry_ctrl #(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         KeyRead,
  input  logic [3:0]                   BCDKey,
  output logic [4*DIGITS-1:0]          Operand,
  output logic [$clog2(DIGITS+1)-1:0]  DigitCount,
  output logic [1:0]                   OpCode,
  output logic                         CmdValid,
  input  logic                         CmdReady,
  output logic                         Overflow
);

  localparam int unsigned CW   = $clog2(DIGITS + 1);
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);

  localparam logic [CW-1:0]   DigitsMax = CW'(DIGITS);
  localparam logic [CntW-1:0] CntLast   = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] StIdle        = 3'd0;
  localparam logic [2:0] StDebounce    = 3'd1;
  localparam logic [2:0] StAccept      = 3'd2;
  localparam logic [2:0] StPresent     = 3'd3;
  localparam logic [2:0] StWaitRelease = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [3:0]          key_q, key_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [4*DIGITS-1:0] operand_q, operand_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [1:0]          opcode_q, opcode_d;
  logic [4*DIGITS-1:0] digit_ext;

  // Next-state logic: debounce, key decode and command handshake.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    cnt_d     = cnt_q;
    operand_d = operand_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    opcode_d  = opcode_q;
    digit_ext = '0;
    digit_ext[3:0] = key_q;

    case (state_q)
      StIdle: begin
        if (KeyRead) begin
          key_d   = BCDKey;
          cnt_d   = '0;
          state_d = StDebounce;
        end
      end

      StDebounce: begin
        if (KeyRead && (BCDKey == key_q)) begin
          if (cnt_q == CntLast) begin
            state_d = StAccept;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          // Glitch or code change: drop the press silently.
          state_d = StIdle;
        end
      end

      StAccept: begin
        state_d = StWaitRelease;
        cnt_d   = '0;
        if (key_q <= 4'd9) begin
          if (count_q == DigitsMax) begin
            ovf_d = 1'b1;
          end else if (!((key_q == 4'd0) && (count_q == '0))) begin
            // Leading zeros are not stored.
            operand_d = (operand_q << 4) | digit_ext;
            count_d   = count_q + 1'b1;
          end
        end else if (key_q <= 4'hD) begin
          opcode_d = 2'(key_q - 4'hA);
          state_d  = StPresent;
        end else if (key_q == 4'hE) begin
          operand_d = '0;
          count_d   = '0;
          ovf_d     = 1'b0;
        end else begin
`ifdef KEY_BACKSPACE_EN
          if (count_q != '0) begin
            operand_d = operand_q >> 4;
            count_d   = count_q - 1'b1;
            ovf_d     = 1'b0;
          end
`endif
        end
      end

      StPresent: begin
        if (CmdReady) begin
          operand_d = '0;
          count_d   = '0;
          ovf_d     = 1'b0;
          cnt_d     = '0;
          state_d   = StWaitRelease;
        end
      end

      StWaitRelease: begin
        if (KeyRead) begin
          cnt_d = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      key_q     <= '0;
      cnt_q     <= '0;
      operand_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      opcode_q  <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      cnt_q     <= cnt_d;
      operand_q <= operand_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      opcode_q  <= opcode_d;
    end
  end

  assign Operand    = operand_q;
  assign DigitCount = count_q;
  assign OpCode     = opcode_q;
  assign Overflow   = ovf_q;
  assign CmdValid   = (state_q == StPresent);

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Scoreboard bench for key_entry_ctrl: stimulus pushes expected output tuples and
// transfers; a monitor pops and compares whenever outputs change or a transfer occurs.
module tb_key_entry_ctrl;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DB     = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        KeyRead = 1'b0;
  logic [3:0]  BCDKey = 4'd0;
  logic        CmdReady = 1'b0;
  logic [15:0] Operand;
  logic [2:0]  DigitCount;
  logic [1:0]  OpCode;
  logic        CmdValid;
  logic        Overflow;

  key_entry_ctrl #(
    .DIGITS          (DIGITS),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .KeyRead    (KeyRead),
    .BCDKey     (BCDKey),
    .Operand    (Operand),
    .DigitCount (DigitCount),
    .OpCode     (OpCode),
    .CmdValid   (CmdValid),
    .CmdReady   (CmdReady),
    .Overflow   (Overflow)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef logic [22:0] tup_t;  // {Operand, DigitCount, Overflow, CmdValid, OpCode}

  tup_t        exp_q[$];
  int          exp_cyc_q[$];
  string       name_q[$];
  logic [17:0] xfer_q[$];      // {Operand, OpCode}
  int          checks = 0;
  int          fails  = 0;
  bit          mon_en = 1'b0;
  bit          first  = 1'b1;
  tup_t        prev, cur, e;
  int          ec;
  string       nm;
  bit          xfer;
  logic [17:0] xd, xe;

  function automatic tup_t mk(input logic [15:0] op, input logic [2:0] cnt, input logic ovf,
                              input logic vld, input logic [1:0] opc);
    return {op, cnt, ovf, vld, opc};
  endfunction

  task automatic expect_at(input string n, input tup_t t, input int c);
    name_q.push_back(n);
    exp_q.push_back(t);
    exp_cyc_q.push_back(c);
  endtask

  // Called right after a negedge; an accepted key changes outputs 6 edges later.
  task automatic press(input logic [3:0] k, input int hold, input int rel, input bit chg,
                       input tup_t t, input string n);
    KeyRead = 1'b1;
    BCDKey  = k;
    if (chg) expect_at(n, t, cyc + 6);
    repeat (hold) @(negedge CLK);
    KeyRead = 1'b0;
    repeat (rel) @(negedge CLK);
  endtask

  // Monitor: transfers sampled at the edge, output tuple sampled just after it.
  initial begin
    wait (mon_en);
    forever begin
      @(posedge CLK);
      xfer = CmdValid && CmdReady && !RESET;
      xd   = {Operand, OpCode};
      #1;
      cur = {Operand, DigitCount, Overflow, CmdValid, OpCode};
      if (xfer) begin
        checks++;
        if (xfer_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_transfer: got %h, none required", xd);
        end else begin
          xe = xfer_q.pop_front();
          if (xd !== xe) begin
            fails++;
            $display("FAIL transfer: got %h required %h", xd, xe);
          end
        end
      end
      if (first || cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change: got %h at cycle %0d, no change required", cur, cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          nm = name_q.pop_front();
          if (cur !== e) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, cur, e);
          end
          if (ec >= 0) begin
            checks++;
            if (cyc != ec) begin
              fails++;
              $display("FAIL %s_latency: got cycle %0d required %0d", nm, cyc, ec);
            end
          end
        end
      end
      prev  = cur;
      first = 1'b0;
    end
  end

  initial begin
    repeat (3) @(negedge CLK);
    expect_at("reset", mk(16'h0, 3'd0, 0, 0, 2'd0), -1);
    mon_en = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    // Digit entry with latency check
    press(4'd1, 6, 6, 1, mk(16'h0001, 3'd1, 0, 0, 2'd0), "digit1");
    press(4'd2, 6, 6, 1, mk(16'h0012, 3'd2, 0, 0, 2'd0), "digit2");
    press(4'd3, 6, 6, 1, mk(16'h0123, 3'd3, 0, 0, 2'd0), "digit3");
`ifdef KEY_BACKSPACE_EN
    press(4'hF, 6, 6, 1, mk(16'h0012, 3'd2, 0, 0, 2'd0), "backspace");
`else
    press(4'hF, 6, 6, 0, mk(16'h0123, 3'd3, 0, 0, 2'd0), "backspace_off");
`endif
    press(4'hE, 6, 6, 1, mk(16'h0, 3'd0, 0, 0, 2'd0), "clear1");
    press(4'hF, 6, 6, 0, mk(16'h0, 3'd0, 0, 0, 2'd0), "backspace_empty");

    // Leading zero suppression
    press(4'd0, 6, 6, 0, mk(16'h0, 3'd0, 0, 0, 2'd0), "lead_zero");
    press(4'd7, 6, 6, 1, mk(16'h0007, 3'd1, 0, 0, 2'd0), "digit7");
    press(4'hE, 6, 6, 1, mk(16'h0, 3'd0, 0, 0, 2'd0), "clear2");

    // Fill and overflow
    press(4'd1, 6, 6, 1, mk(16'h0001, 3'd1, 0, 0, 2'd0), "fill1");
    press(4'd2, 6, 6, 1, mk(16'h0012, 3'd2, 0, 0, 2'd0), "fill2");
    press(4'd3, 6, 6, 1, mk(16'h0123, 3'd3, 0, 0, 2'd0), "fill3");
    press(4'd4, 6, 6, 1, mk(16'h1234, 3'd4, 0, 0, 2'd0), "fill4");
    press(4'd5, 6, 6, 1, mk(16'h1234, 3'd4, 1, 0, 2'd0), "overflow");
    press(4'hE, 6, 6, 1, mk(16'h0, 3'd0, 0, 0, 2'd0), "clear3");

    // Operator with back-pressure
    press(4'd4, 6, 6, 1, mk(16'h0004, 3'd1, 0, 0, 2'd0), "op_d4");
    press(4'd2, 6, 6, 1, mk(16'h0042, 3'd2, 0, 0, 2'd0), "op_d2");
    press(4'hA, 6, 12, 1, mk(16'h0042, 3'd2, 0, 1, 2'd0), "present_add");
    CmdReady = 1'b1;
    xfer_q.push_back({16'h0042, 2'd0});
    expect_at("after_xfer", mk(16'h0, 3'd0, 0, 0, 2'd0), cyc + 1);
    @(negedge CLK);
    CmdReady = 1'b0;
    repeat (6) @(negedge CLK);

    // Glitch rejection
    KeyRead = 1'b1; BCDKey = 4'd5;
    repeat (2) @(negedge CLK);
    KeyRead = 1'b0;
    repeat (6) @(negedge CLK);
    KeyRead = 1'b1; BCDKey = 4'd5;
    repeat (2) @(negedge CLK);
    BCDKey = 4'd6;
    @(negedge CLK);
    KeyRead = 1'b0;
    repeat (6) @(negedge CLK);

    // Long hold gives one digit
    press(4'd9, 50, 6, 1, mk(16'h0009, 3'd1, 0, 0, 2'd0), "long_hold");

    // Reset while presenting
    press(4'hB, 6, 2, 1, mk(16'h0009, 3'd1, 0, 1, 2'd1), "present_sub");
    RESET = 1'b1;
    expect_at("reset_present", mk(16'h0, 3'd0, 0, 0, 2'd0), cyc + 1);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (6) @(negedge CLK);

    // Reset while debouncing
    press(4'd3, 6, 6, 1, mk(16'h0003, 3'd1, 0, 0, 2'd0), "pre_rst_digit");
    KeyRead = 1'b1; BCDKey = 4'd8;
    repeat (2) @(negedge CLK);
    RESET = 1'b1; KeyRead = 1'b0;
    expect_at("reset_debounce", mk(16'h0, 3'd0, 0, 0, 2'd0), cyc + 1);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (6) @(negedge CLK);

    // Ready already high when equals is presented
    CmdReady = 1'b1;
    press(4'd2, 6, 6, 1, mk(16'h0002, 3'd1, 0, 0, 2'd0), "eq_digit");
    expect_at("present_eq", mk(16'h0002, 3'd1, 0, 1, 2'd3), cyc + 6);
    expect_at("after_eq", mk(16'h0, 3'd0, 0, 0, 2'd3), cyc + 7);
    xfer_q.push_back({16'h0002, 2'd3});
    press(4'hD, 6, 6, 0, mk(16'h0, 3'd0, 0, 0, 2'd0), "eq");
    CmdReady = 1'b0;
    repeat (10) @(negedge CLK);

    checks++;
    if (exp_q.size() != 0 || xfer_q.size() != 0) begin
      fails++;
      $display("FAIL drained: got %0d outputs and %0d transfers pending, required 0 and 0",
               exp_q.size(), xfer_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
